// File: rtl/operand_fwd_stage.sv
// Decode-to-EX operand resolution stage: forwarding from EX/MEM/WB, load-use stall, flush.
// Optional macro FWD_WB_BYPASS_EN enables the WB forwarding path; without it a WB hit stalls.
module operand_fwd_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic [4:0]  id_rd_addr_i,
    input  logic        id_rd_wren_i,
    input  logic        id_is_load_i,
    input  logic [31:0] rf_rs1_data_i,
    input  logic [31:0] rf_rs2_data_i,
    input  logic [31:0] ex_result_i,
    input  logic [31:0] mem_result_i,
    input  logic [4:0]  wb_rd_addr_i,
    input  logic        wb_rd_wren_i,
    input  logic [31:0] wb_rd_data_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        ex_valid_o,
    output logic [31:0] ex_rs1_data_o,
    output logic [31:0] ex_rs2_data_o,
    output logic [4:0]  ex_rd_addr_o,
    output logic        ex_rd_wren_o,
    output logic        ex_is_load_o,
    output logic [15:0] stall_cnt_o
);

    logic        ex_valid_q;
    logic [31:0] ex_rs1_q;
    logic [31:0] ex_rs2_q;
    logic [4:0]  ex_rd_addr_q;
    logic        ex_rd_wren_q;
    logic        ex_is_load_q;

    logic        mem_valid_q;
    logic [4:0]  mem_rd_addr_q;
    logic        mem_rd_wren_q;
    logic        mem_is_load_q;

    logic [15:0] stall_cnt_q;

    logic        rs1_ex_hit, rs2_ex_hit;
    logic        rs1_mem_hit, rs2_mem_hit;
    logic        rs1_wb_hit, rs2_wb_hit;
    logic        load_use;
    logic        wb_stall;
    logic        stall;
    logic [31:0] rs1_res, rs2_res;

    function automatic logic slot_match(input logic v, input logic w,
                                        input logic [4:0] rd, input logic [4:0] src);
        return v & w & (rd == src) & (src != '0);
    endfunction

    // Priority: x0, EX (non-load), MEM, WB (optional), register file.
    function automatic logic [31:0] resolve(input logic [4:0]  src,
                                            input logic        ex_hit,
                                            input logic        ex_is_load,
                                            input logic        mem_hit,
                                            input logic        wb_hit,
                                            input logic [31:0] ex_res,
                                            input logic [31:0] mem_res,
                                            input logic [31:0] wb_res,
                                            input logic [31:0] rf_res);
        logic [31:0] r;
        r = rf_res;
        if (src == '0)
            r = '0;
        else if (ex_hit && !ex_is_load)
            r = ex_res;
        else if (mem_hit)
            r = mem_res;
`ifdef FWD_WB_BYPASS_EN
        else if (wb_hit)
            r = wb_res;
`endif
        return r;
    endfunction

`ifndef FWD_WB_BYPASS_EN
    logic unused_wb_data;
    assign unused_wb_data = ^wb_rd_data_i;
`endif

    always_comb begin
        rs1_ex_hit  = slot_match(ex_valid_q, ex_rd_wren_q, ex_rd_addr_q, id_rs1_addr_i);
        rs2_ex_hit  = slot_match(ex_valid_q, ex_rd_wren_q, ex_rd_addr_q, id_rs2_addr_i);
        rs1_mem_hit = slot_match(mem_valid_q, mem_rd_wren_q, mem_rd_addr_q, id_rs1_addr_i);
        rs2_mem_hit = slot_match(mem_valid_q, mem_rd_wren_q, mem_rd_addr_q, id_rs2_addr_i);
        rs1_wb_hit  = slot_match(1'b1, wb_rd_wren_i, wb_rd_addr_i, id_rs1_addr_i);
        rs2_wb_hit  = slot_match(1'b1, wb_rd_wren_i, wb_rd_addr_i, id_rs2_addr_i);

        load_use = id_valid_i & ex_is_load_q & (rs1_ex_hit | rs2_ex_hit);
`ifdef FWD_WB_BYPASS_EN
        wb_stall = 1'b0;
`else
        wb_stall = id_valid_i &
                   ((rs1_wb_hit & ~rs1_ex_hit & ~rs1_mem_hit) |
                    (rs2_wb_hit & ~rs2_ex_hit & ~rs2_mem_hit));
`endif
        // WB hits come straight from inputs, so reset must gate the stall explicitly.
        stall = ~rst_i & (load_use | wb_stall);

        rs1_res = resolve(id_rs1_addr_i, rs1_ex_hit, ex_is_load_q, rs1_mem_hit, rs1_wb_hit,
                          ex_result_i, mem_result_i, wb_rd_data_i, rf_rs1_data_i);
        rs2_res = resolve(id_rs2_addr_i, rs2_ex_hit, ex_is_load_q, rs2_mem_hit, rs2_wb_hit,
                          ex_result_i, mem_result_i, wb_rd_data_i, rf_rs2_data_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_q   <= 1'b0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_rd_addr_q <= '0;
            ex_rd_wren_q <= 1'b0;
            ex_is_load_q <= 1'b0;
        end else if (flush_i || stall || !id_valid_i) begin
            ex_valid_q   <= 1'b0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_rd_addr_q <= '0;
            ex_rd_wren_q <= 1'b0;
            ex_is_load_q <= 1'b0;
        end else begin
            ex_valid_q   <= 1'b1;
            ex_rs1_q     <= rs1_res;
            ex_rs2_q     <= rs2_res;
            ex_rd_addr_q <= id_rd_addr_i;
            ex_rd_wren_q <= id_rd_wren_i;
            ex_is_load_q <= id_is_load_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_valid_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            mem_rd_wren_q <= 1'b0;
            mem_is_load_q <= 1'b0;
        end else begin
            mem_valid_q   <= ex_valid_q;
            mem_rd_addr_q <= ex_rd_addr_q;
            mem_rd_wren_q <= ex_rd_wren_q;
            mem_is_load_q <= ex_is_load_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    logic unused_mem_is_load;
    assign unused_mem_is_load = mem_is_load_q;

    assign stall_o       = stall;
    assign ex_valid_o    = ex_valid_q;
    assign ex_rs1_data_o = ex_rs1_q;
    assign ex_rs2_data_o = ex_rs2_q;
    assign ex_rd_addr_o  = ex_rd_addr_q;
    assign ex_rd_wren_o  = ex_rd_wren_q;
    assign ex_is_load_o  = ex_is_load_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_operand_fwd_stage.sv
// Scoreboard bench for operand_fwd_stage: expected EX slot contents are queued at drive time
// and compared one edge later.
module tb_operand_fwd_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic        id_rd_wren_i, id_is_load_i;
    logic [31:0] rf_rs1_data_i, rf_rs2_data_i;
    logic [31:0] ex_result_i, mem_result_i;
    logic [4:0]  wb_rd_addr_i;
    logic        wb_rd_wren_i;
    logic [31:0] wb_rd_data_i;
    logic        flush_i;
    logic        stall_o;
    logic        ex_valid_o;
    logic [31:0] ex_rs1_data_o, ex_rs2_data_o;
    logic [4:0]  ex_rd_addr_o;
    logic        ex_rd_wren_o, ex_is_load_o;
    logic [15:0] stall_cnt_o;

    localparam logic [31:0] RF1 = 32'h1111_1111;
    localparam logic [31:0] RF2 = 32'h2222_2222;

    typedef struct packed {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        w;
        logic        l;
    } ex_t;

    ex_t         exp_q[$];
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    logic [15:0] exp_cnt = '0;

    operand_fwd_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rd_addr_i(id_rd_addr_i), .id_rd_wren_i(id_rd_wren_i), .id_is_load_i(id_is_load_i),
        .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
        .ex_result_i(ex_result_i), .mem_result_i(mem_result_i),
        .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_wren_i(wb_rd_wren_i), .wb_rd_data_i(wb_rd_data_i),
        .flush_i(flush_i), .stall_o(stall_o), .ex_valid_o(ex_valid_o),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_rd_addr_o(ex_rd_addr_o), .ex_rd_wren_o(ex_rd_wren_o), .ex_is_load_o(ex_is_load_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic w, input logic l);
        id_valid_i = v; id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
        id_rd_addr_i = rd; id_rd_wren_i = w; id_is_load_i = l;
    endtask

    task automatic post_edge_check(input string tag);
        ex_t e;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".valid"}, {31'd0, ex_valid_o}, {31'd0, e.v});
            check({tag, ".rs1"}, ex_rs1_data_o, e.a);
            check({tag, ".rs2"}, ex_rs2_data_o, e.b);
            check({tag, ".rd"}, {27'd0, ex_rd_addr_o}, {27'd0, e.rd});
            check({tag, ".wren"}, {31'd0, ex_rd_wren_o}, {31'd0, e.w});
            check({tag, ".load"}, {31'd0, ex_is_load_o}, {31'd0, e.l});
        end
    endtask

    // One decode cycle: queue the EX slot expected after the coming edge, check stall mid-cycle.
    task automatic cycle(input string tag, input logic exp_stall, input ex_t e);
        exp_q.push_back(e);
        @(negedge clk_i);
        check({tag, ".stall"}, {31'd0, stall_o}, {31'd0, exp_stall});
        if (exp_stall && exp_cnt != 16'hFFFF) exp_cnt++;
        @(posedge clk_i);
        #1;
        post_edge_check(tag);
    endtask

    task automatic idle(input int unsigned n);
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        ex_result_i = '0; mem_result_i = '0; flush_i = 1'b0;
        for (int unsigned i = 0; i < n; i++) cycle("idle", 1'b0, '0);
    endtask

    initial begin
        rst_i = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rf_rs1_data_i = RF1; rf_rs2_data_i = RF2;
        ex_result_i = '0; mem_result_i = '0;
        wb_rd_addr_i = '0; wb_rd_wren_i = 1'b0; wb_rd_data_i = '0; flush_i = 1'b0;
        #2;
        check("rst.valid", {31'd0, ex_valid_o}, 32'd0);
        check("rst.rs1", ex_rs1_data_o, 32'd0);
        check("rst.cnt", {16'd0, stall_cnt_o}, 32'd0);
        // A WB hit under reset must not raise stall.
        wb_rd_addr_i = 5'd3; wb_rd_wren_i = 1'b1; set_id(1'b1, 5'd3, 5'd0, 5'd1, 1'b1, 1'b0);
        #1;
        check("rst.stall", {31'd0, stall_o}, 32'd0);
        wb_rd_wren_i = 1'b0; wb_rd_addr_i = '0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // EX forwarding to both operands
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        cycle("add5", 1'b0, '{v:1'b1, a:RF1, b:RF2, rd:5'd5, w:1'b1, l:1'b0});
        set_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0); ex_result_i = 32'h1234;
        cycle("fwd_ex", 1'b0, '{v:1'b1, a:32'h1234, b:32'h1234, rd:5'd6, w:1'b1, l:1'b0});
        idle(2);

        // Load-use: one stall, bubble, then MEM forward
        set_id(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
        cycle("lw7", 1'b0, '{v:1'b1, a:RF1, b:32'd0, rd:5'd7, w:1'b1, l:1'b1});
        set_id(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0); mem_result_i = 32'hCAFE_0000;
        cycle("lu_stall", 1'b1, '0);
        cycle("lu_fwd", 1'b0, '{v:1'b1, a:32'hCAFE_0000, b:RF2, rd:5'd8, w:1'b1, l:1'b0});
        check("lu.cnt", {16'd0, stall_cnt_o}, 32'd1);
        idle(2);

        // x0 is never forwarded
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        cycle("wr_x0", 1'b0, '{v:1'b1, a:RF1, b:RF2, rd:5'd0, w:1'b1, l:1'b0});
        set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0); ex_result_i = 32'hFFFF_FFFF;
        cycle("rd_x0", 1'b0, '{v:1'b1, a:32'd0, b:32'd0, rd:5'd9, w:1'b1, l:1'b0});
        idle(2);

        // WB hit
        wb_rd_addr_i = 5'd3; wb_rd_wren_i = 1'b1; wb_rd_data_i = 32'hA5A5_A5A5; rf_rs1_data_i = '0;
        set_id(1'b1, 5'd3, 5'd2, 5'd10, 1'b1, 1'b0);
`ifdef FWD_WB_BYPASS_EN
        cycle("wb_fwd", 1'b0, '{v:1'b1, a:32'hA5A5_A5A5, b:RF2, rd:5'd10, w:1'b1, l:1'b0});
`else
        cycle("wb_stall", 1'b1, '0);
        wb_rd_wren_i = 1'b0; rf_rs1_data_i = 32'hA5A5_A5A5;
        cycle("wb_rf", 1'b0, '{v:1'b1, a:32'hA5A5_A5A5, b:RF2, rd:5'd10, w:1'b1, l:1'b0});
`endif
        wb_rd_wren_i = 1'b0; rf_rs1_data_i = RF1;
        check("wb.cnt", {16'd0, stall_cnt_o}, {16'd0, exp_cnt});
        idle(2);

        // Flush alone, then flush coincident with load-use
        set_id(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0); flush_i = 1'b1;
        cycle("flush", 1'b0, '0);
        flush_i = 1'b0;
        set_id(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
        cycle("lw7b", 1'b0, '{v:1'b1, a:RF1, b:32'd0, rd:5'd7, w:1'b1, l:1'b1});
        set_id(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0); flush_i = 1'b1;
        cycle("flush_lu", 1'b1, '0);
        check("flush.cnt", {16'd0, stall_cnt_o}, {16'd0, exp_cnt});
        idle(2);

        // Reset pulse between edges during a load-use stall
        set_id(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1);
        cycle("lw7c", 1'b0, '{v:1'b1, a:RF1, b:32'd0, rd:5'd7, w:1'b1, l:1'b1});
        set_id(1'b1, 5'd7, 5'd1, 5'd8, 1'b1, 1'b0);
        @(negedge clk_i);
        check("mid.stall_pre", {31'd0, stall_o}, 32'd1);
        #1 rst_i = 1'b1;
        #1;
        check("mid.valid", {31'd0, ex_valid_o}, 32'd0);
        check("mid.rs1", ex_rs1_data_o, 32'd0);
        check("mid.rd", {27'd0, ex_rd_addr_o}, 32'd0);
        check("mid.load", {31'd0, ex_is_load_o}, 32'd0);
        check("mid.cnt", {16'd0, stall_cnt_o}, 32'd0);
        check("mid.stall", {31'd0, stall_o}, 32'd0);
        #1 rst_i = 1'b0;
        exp_cnt = '0;
        exp_q.push_back('{v:1'b1, a:RF1, b:RF2, rd:5'd8, w:1'b1, l:1'b0});
        @(posedge clk_i); #1;
        post_edge_check("post_rst");
        idle(1);

`ifndef FWD_WB_BYPASS_EN
        // Continuous WB stall drives the counter into saturation
        wb_rd_addr_i = 5'd3; wb_rd_wren_i = 1'b1;
        set_id(1'b1, 5'd3, 5'd0, 5'd12, 1'b1, 1'b0);
        @(negedge clk_i);
        repeat (65534) @(posedge clk_i);
        #1;
        check("sat.fffe", {16'd0, stall_cnt_o}, 32'h0000_FFFE);
        repeat (4) @(posedge clk_i);
        #1;
        check("sat.ffff", {16'd0, stall_cnt_o}, 32'h0000_FFFF);
        check("sat.stall", {31'd0, stall_o}, 32'd1);
        wb_rd_wren_i = 1'b0;
        idle(1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
